// File: rtl/stack_controller.sv
// stack_controller: multicycle Moore control unit for the stack-machine datapath.
// Each instruction runs a fixed 3-6 state sequence that starts and ends at FETCH.
//
// Ports:
//   clk            system clock, rising-edge
//   rst            synchronous active-high reset; forces all outputs low while high
//   opc[2:0]       opcode from IR[7:5], sampled in DECODE, POP1 and EXEC only
//   pcWriteUnCond  unconditional PC load
//   pcWriteCond    PC load gated by the datapath zero flag
//   IorD           memory address select (0 = PC, 1 = IR[4:0])
//   memRead        memory read strobe
//   memWrite       memory write strobe (A -> mem[IR[4:0]])
//   IRWrite        load IR from memory
//   MtoS           stack din select (0 = ALU result reg, 1 = MDR)
//   push, pop      stack push / pop
//   tos            present top-of-stack without popping
//   ldA, ldB       load A / B from stackOut
//   srcA           ALU A select (0 = PC, 1 = A)
//   srcB           ALU B select (0 = B, 1 = constant 1)
//   pcSrc          PC input select (0 = ALU result, 1 = IR[4:0])
//   aluOp[1:0]     00 ADD, 01 SUB, 10 AND, 11 NOT(A)
//   done           one-cycle pulse in the last state of each instruction
module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opc,
    output logic       pcWriteUnCond,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       pcSrc,
    output logic [1:0] aluOp,
    output logic       done
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StPop1   = 4'd2,
        StPop2   = 4'd3,
        StExec   = 4'd4,
        StStwb   = 4'd5,
        StMemRd  = 4'd6,
        StMdrWb  = 4'd7,
        StMemWr  = 4'd8,
        StJmp    = 4'd9,
        StJz     = 4'd10
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; encodings 11-15 and unexpected opcodes fall back to FETCH.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (opc)
                    3'b100:  state_d = StMemRd;
                    3'b110:  state_d = StJmp;
                    3'b111:  state_d = StJz;
                    default: state_d = StPop1;
                endcase
            end
            StPop1: begin
                case (opc)
                    3'b000, 3'b001, 3'b010: state_d = StPop2;
                    3'b011:                 state_d = StExec;
                    3'b101:                 state_d = StMemWr;
                    default:                state_d = StFetch;
                endcase
            end
            StPop2:  state_d = StExec;
            StExec:  state_d = StStwb;
            StMemRd: state_d = StMdrWb;
            default: state_d = StFetch;
        endcase
    end

    // Moore output decode; rst overrides the decode so nothing strobes during reset.
    always_comb begin
        pcWriteUnCond = 1'b0;
        pcWriteCond   = 1'b0;
        IorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        IRWrite       = 1'b0;
        MtoS          = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        tos           = 1'b0;
        ldA           = 1'b0;
        ldB           = 1'b0;
        srcA          = 1'b0;
        srcB          = 1'b0;
        pcSrc         = 1'b0;
        aluOp         = 2'b00;
        done          = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    // PC <= PC + 1 in parallel with the instruction read.
                    memRead       = 1'b1;
                    IRWrite       = 1'b1;
                    srcB          = 1'b1;
                    pcWriteUnCond = 1'b1;
                end
                StDecode: tos = 1'b1;
                StPop1: begin
                    pop = 1'b1;
                    ldA = 1'b1;
                end
                StPop2: begin
                    pop = 1'b1;
                    ldB = 1'b1;
                end
                StExec: begin
                    srcA  = 1'b1;
                    aluOp = (opc == 3'b011) ? 2'b11 : opc[1:0];
                end
                StStwb: begin
                    push = 1'b1;
                    done = 1'b1;
                end
                StMemRd: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                end
                StMdrWb: begin
                    MtoS = 1'b1;
                    push = 1'b1;
                    done = 1'b1;
                end
                StMemWr: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    done     = 1'b1;
                end
                StJmp: begin
                    pcSrc         = 1'b1;
                    pcWriteUnCond = 1'b1;
                    done          = 1'b1;
                end
                StJz: begin
                    pcSrc       = 1'b1;
                    pcWriteCond = 1'b1;
                    done        = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Multicycle control unit for the stack-machine datapath. Consumes the 3-bit opcode `opc` (IR[7:5]) and drives every datapath control strobe, one state per clock.
- Moore FSM. Each instruction is a fixed-length sequence of 3–6 cycles that always starts and ends at FETCH.
- Sits beside the datapath in the CPU top level. There is no handshake beyond the shared clock.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opc  input  3  opcode from IR[7:5]; valid from the DECODE state onward.
- pcWriteUnCond  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load qualified by datapath zero flag.
- IorD  output  1  0 = address from PC, 1 = address from IR[4:0].
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe; writes A to IR[4:0].
- IRWrite  output  1  load IR from memory output.
- MtoS  output  1  stack din select: 0 = ALU result register, 1 = MDR.
- push  output  1  push din onto stack.
- pop  output  1  pop stack.
- tos  output  1  present top-of-stack on stackOut without popping.
- ldA  output  1  load A from stackOut.
- ldB  output  1  load B from stackOut.
- srcA  output  1  ALU A select: 0 = PC, 1 = A.
- srcB  output  1  ALU B select: 0 = B, 1 = constant 1.
- pcSrc  output  1  PC input select: 0 = ALU result, 1 = IR[4:0].
- aluOp  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT(A).
- done  output  1  one-cycle pulse in the last state of each instruction.

Behaviour:
- Opcode map:
  - 000 ADD, 001 SUB, 010 AND, 011 NOT
  - 100 PUSH addr, 101 POP addr
  - 110 JMP addr, 111 JZ addr
- Reset (synchronous, active-high):
  - rst high at a rising edge forces state = FETCH.
  - While rst is high, all outputs are forced to 0, overriding the state decode.
  - rst asserted mid-instruction abandons the instruction at the next edge; no partial strobe follows.
- Outputs are a pure function of state (and opc only for aluOp in EXEC). Every output not listed for a state is 0.
- States and transitions (A = asserted signals -> next state):
  - FETCH: IorD=0, memRead, IRWrite, srcA=0, srcB=1, aluOp=00, pcSrc=0, pcWriteUnCond -> DECODE.
  - DECODE: tos (zero flag captures top of stack).
    - opc 000/001/010 -> POP1
    - 011 -> POP1
    - 100 -> MEMRD
    - 101 -> POP1
    - 110 -> JMP
    - 111 -> JZ
  - POP1: pop, ldA.
    - opc 000–010 -> POP2
    - 011 -> EXEC
    - 101 -> MEMWR
  - POP2: pop, ldB -> EXEC.
  - EXEC: srcA=1, srcB=0, aluOp = (opc==011) ? 11 : opc[1:0] -> STWB (ALU result register captures).
  - STWB: MtoS=0, push, done -> FETCH.
  - MEMRD: IorD=1, memRead (MDR captures) -> MDRWB.
  - MDRWB: MtoS=1, push, done -> FETCH.
  - MEMWR: IorD=1, memWrite, done -> FETCH.
  - JMP: pcSrc=1, pcWriteUnCond, done -> FETCH.
  - JZ: pcSrc=1, pcWriteCond, done -> FETCH.
    - The controller never sees zero; the datapath gates pcWriteCond with it.
- Latency (cycles from FETCH to the next FETCH):
  - ADD/SUB/AND 6; NOT 5
  - PUSH 4; POP 4
  - JMP 3; JZ 3
- Mutual exclusion:
  - push and pop never asserted together.
  - memRead and memWrite never asserted together.
  - pcWriteUnCond and pcWriteCond never asserted together.
- opc is sampled only in DECODE, POP1 and EXEC. Changes in opc in other states have no effect.
- State register is 4 bits. Any unused encoding transitions to FETCH on the next edge with all outputs 0.

Test Plan:
- rst=1 for 2 cycles, then release -> all outputs 0 while rst=1; first cycle after release shows FETCH strobes (memRead=IRWrite=pcWriteUnCond=srcB=1); DECODE follows with tos=1.
- opc=001 (SUB) -> state sequence FETCH, DECODE, POP1(pop, ldA), POP2(pop, ldB), EXEC(aluOp=01, srcA=1, srcB=0), STWB(push, MtoS=0, done) -> FETCH at cycle 7.
- opc=100 (PUSH) -> MEMRD(IorD=1, memRead=1) then MDRWB(MtoS=1, push=1, done=1); done pulses exactly once in 4 cycles. opc=101 (POP) -> POP1 then MEMWR(IorD=1, memWrite=1, done=1).
- opc=111 (JZ) -> JZ state with pcSrc=1, pcWriteCond=1, pcWriteUnCond=0; opc=110 (JMP) -> pcWriteUnCond=1, pcWriteCond=0; each returns to FETCH after 3 cycles.
- opc=011 (NOT) -> no POP2; EXEC has aluOp=11; 5-cycle instruction.
- Assert rst during POP2 of an ADD -> all outputs 0 next cycle; FETCH resumes after release; no push ever issued for the aborted ADD. Across all tests, an assertion checks the mutual-exclusion rules every cycle.
